// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy encoding, skid states,
// per-stage bundle widths and the architectural PC reset value.
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Packed bundle widths carried between core stages.
    localparam int unsigned IF_ID_W  = 96;
    localparam int unsigned ID_EX_W  = 192;
    localparam int unsigned EX_MEM_W = 144;
    localparam int unsigned MEM_WB_W = 104;

    localparam logic [63:0] PC_RESET_VAL = 64'h8000_0000;

    // Encoded as {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } skid_state_e;

    function automatic logic [1:0] occ_of(input logic main_v, input logic skid_v);
        if (skid_v) begin
            return OCC_FULL;
        end else if (main_v) begin
            return OCC_ONE;
        end
        return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle; master drives valid/data, slave drives ready.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 64
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_inc && (r_cnt != '1)) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: valid/ready payload slot with flush, optional 2-entry
// skid buffer (registered upstream ready) and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int unsigned       SKID      = 1,
    parameter int unsigned       CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stage_reg_if.slave    in_if,
    pipe_stage_reg_if.master   out_if,
    input  logic               flush,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    input  logic               stall_cnt_clr
);

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_valid;
    logic [DATA_W-1:0] w_main_data;
    logic [1:0]        w_occ;

    assign w_in_fire  = in_if.valid & w_in_ready;
    assign w_out_fire = w_main_valid & out_if.ready;

    assign in_if.ready  = w_in_ready;
    assign out_if.valid = w_main_valid;
    assign out_if.data  = w_main_data;
    assign occupancy    = w_occ;

    if (SKID != 0) begin : g_skid
        skid_state_e       r_state;
        skid_state_e       w_state_d;
        logic [DATA_W-1:0] r_main_data;
        logic [DATA_W-1:0] r_skid_data;
        logic [DATA_W-1:0] w_main_data_d;
        logic [DATA_W-1:0] w_skid_data_d;
        logic [1:0]        r_occ;

        always_comb begin
            w_state_d     = r_state;
            w_main_data_d = r_main_data;
            w_skid_data_d = r_skid_data;
            unique case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        w_main_data_d = in_if.data;
                        w_state_d     = StOne;
                    end
                end
                StOne: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_data_d = in_if.data;
                    end else if (w_in_fire) begin
                        w_skid_data_d = in_if.data;
                        w_state_d     = StFull;
                    end else if (w_out_fire) begin
                        w_state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (w_out_fire) begin
                        w_main_data_d = r_skid_data;
                        w_state_d     = StOne;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
            // Payload is frozen on flush so a killed beat never reaches out_data.
            if (flush) begin
                w_state_d     = StEmpty;
                w_main_data_d = r_main_data;
                w_skid_data_d = r_skid_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state     <= StEmpty;
                r_main_data <= RESET_VAL;
                r_skid_data <= RESET_VAL;
                r_occ       <= OCC_EMPTY;
            end else begin
                r_state     <= w_state_d;
                r_main_data <= w_main_data_d;
                r_skid_data <= w_skid_data_d;
                r_occ       <= occ_of(w_state_d[0], w_state_d[1]);
            end
        end

        assign w_in_ready   = ~r_state[1];
        assign w_main_valid = r_state[0];
        assign w_main_data  = r_main_data;
        assign w_occ        = r_occ;
    end else begin : g_single
        logic              r_main_valid;
        logic              w_main_valid_d;
        logic [DATA_W-1:0] r_main_data;
        logic [DATA_W-1:0] w_main_data_d;
        logic [1:0]        r_occ;

        always_comb begin
            w_main_valid_d = r_main_valid;
            w_main_data_d  = r_main_data;
            if (flush) begin
                w_main_valid_d = 1'b0;
            end else if (w_in_fire) begin
                w_main_valid_d = 1'b1;
                w_main_data_d  = in_if.data;
            end else if (w_out_fire) begin
                w_main_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_main_valid <= 1'b0;
                r_main_data  <= RESET_VAL;
                r_occ        <= OCC_EMPTY;
            end else begin
                r_main_valid <= w_main_valid_d;
                r_main_data  <= w_main_data_d;
                r_occ        <= occ_of(w_main_valid_d, 1'b0);
            end
        end

        assign w_in_ready   = ~r_main_valid | out_if.ready;
        assign w_main_valid = r_main_valid;
        assign w_main_data  = r_main_data;
        assign w_occ        = r_occ;
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_main_valid & ~out_if.ready),
        .i_clr (stall_cnt_clr),
        .o_cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid (A), single-entry (B) and 4-bit counter (C) builds.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        ov;
        logic [63:0] od;
        logic [1:0]  occ;
        logic        ir;
        logic [31:0] st;
    } vec_t;

    localparam int NV = 19;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic        a_flush, a_clr;
    logic [1:0]  a_occ;
    logic [31:0] a_stall;
    logic        b_flush, b_clr;
    logic [1:0]  b_occ;
    logic [7:0]  b_stall;
    logic        c_flush, c_clr;
    logic [1:0]  c_occ;
    logic [3:0]  c_stall;

    pipe_stage_reg_if #(.DATA_W(64)) a_in ();
    pipe_stage_reg_if #(.DATA_W(64)) a_out ();
    pipe_stage_reg_if #(.DATA_W(8))  b_in ();
    pipe_stage_reg_if #(.DATA_W(8))  b_out ();
    pipe_stage_reg_if #(.DATA_W(16)) c_in ();
    pipe_stage_reg_if #(.DATA_W(16)) c_out ();

    pipe_stage_reg #(
        .DATA_W(64), .RESET_VAL(PC_RESET_VAL), .SKID(1), .CNT_W(32)
    ) u_a (
        .clk(clk), .rst(rst), .in_if(a_in), .out_if(a_out), .flush(a_flush),
        .occupancy(a_occ), .stall_cnt(a_stall), .stall_cnt_clr(a_clr)
    );

    pipe_stage_reg #(
        .DATA_W(8), .RESET_VAL(8'h00), .SKID(0), .CNT_W(8)
    ) u_b (
        .clk(clk), .rst(rst), .in_if(b_in), .out_if(b_out), .flush(b_flush),
        .occupancy(b_occ), .stall_cnt(b_stall), .stall_cnt_clr(b_clr)
    );

    pipe_stage_reg #(
        .DATA_W(16), .RESET_VAL(16'h0000), .SKID(1), .CNT_W(4)
    ) u_c (
        .clk(clk), .rst(rst), .in_if(c_in), .out_if(c_out), .flush(c_flush),
        .occupancy(c_occ), .stall_cnt(c_stall), .stall_cnt_clr(c_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input logic [63:0] d, input logic ordy,
                                input logic fl, input logic clr, input logic ov,
                                input logic [63:0] od, input logic [1:0] occ,
                                input logic ir, input logic [31:0] st);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.ov = ov; v.od = od; v.occ = occ; v.ir = ir; v.st = st;
        return v;
    endfunction

    // Invariants: held data stable under stall, occupancy legal, killed beat never shown.
    logic        a_prev_stall, b_prev_stall;
    logic [63:0] a_prev_data;
    logic [7:0]  b_prev_data;

    initial begin
        a_prev_stall = 1'b0;
        b_prev_stall = 1'b0;
        a_prev_data  = '0;
        b_prev_data  = '0;
    end

    always @(negedge clk) begin
        if (a_prev_stall) begin
            total++;
            if (!(a_out.valid && a_out.data == a_prev_data)) begin
                bad++;
                $display("FAIL a_hold: valid=%b data=%h want data %h", a_out.valid,
                         a_out.data, a_prev_data);
            end
        end
        if (b_prev_stall) begin
            total++;
            if (!(b_out.valid && b_out.data == b_prev_data)) begin
                bad++;
                $display("FAIL b_hold: valid=%b data=%h want data %h", b_out.valid,
                         b_out.data, b_prev_data);
            end
        end
        total++;
        if (a_occ == 2'd3 || (a_out.valid != (a_occ != 2'd0)) ||
            (a_out.valid && a_out.data == 64'h44) || b_occ > 2'd1) begin
            bad++;
            $display("FAIL inv: a_occ=%0d a_valid=%b a_data=%h b_occ=%0d", a_occ,
                     a_out.valid, a_out.data, b_occ);
        end
        a_prev_stall <= !rst && !a_flush && a_out.valid && !a_out.ready;
        b_prev_stall <= !rst && !b_flush && b_out.valid && !b_out.ready;
        a_prev_data  <= a_out.data;
        b_prev_data  <= b_out.data;
    end

    vec_t vecs[NV];

    initial begin
        total = 0;
        bad   = 0;

        //        iv    d        ordy  fl    clr   ov    od        occ   ir    st
        vecs[0]  = mk(1'b1, 64'h1,  1'b1, 1'b0, 1'b0, 1'b1, 64'h1,  2'd1, 1'b1, 32'd0);
        vecs[1]  = mk(1'b1, 64'h2,  1'b1, 1'b0, 1'b0, 1'b1, 64'h2,  2'd1, 1'b1, 32'd0);
        vecs[2]  = mk(1'b1, 64'h3,  1'b1, 1'b0, 1'b0, 1'b1, 64'h3,  2'd1, 1'b1, 32'd0);
        vecs[3]  = mk(1'b1, 64'h4,  1'b1, 1'b0, 1'b0, 1'b1, 64'h4,  2'd1, 1'b1, 32'd0);
        vecs[4]  = mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h4,  2'd0, 1'b1, 32'd0);
        vecs[5]  = mk(1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 2'd1, 1'b1, 32'd0);
        vecs[6]  = mk(1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 2'd2, 1'b0, 32'd1);
        vecs[7]  = mk(1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 2'd2, 1'b0, 32'd2);
        vecs[8]  = mk(1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 2'd2, 1'b0, 32'd3);
        vecs[9]  = mk(1'b1, 64'h33, 1'b1, 1'b0, 1'b0, 1'b1, 64'h22, 2'd1, 1'b1, 32'd3);
        vecs[10] = mk(1'b1, 64'h33, 1'b1, 1'b0, 1'b0, 1'b1, 64'h33, 2'd1, 1'b1, 32'd3);
        vecs[11] = mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h33, 2'd0, 1'b1, 32'd3);
        vecs[12] = mk(1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 2'd1, 1'b1, 32'd3);
        vecs[13] = mk(1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 2'd2, 1'b0, 32'd4);
        vecs[14] = mk(1'b1, 64'h44, 1'b0, 1'b1, 1'b0, 1'b0, 64'h11, 2'd0, 1'b1, 32'd5);
        vecs[15] = mk(1'b1, 64'h55, 1'b0, 1'b0, 1'b0, 1'b1, 64'h55, 2'd1, 1'b1, 32'd5);
        vecs[16] = mk(1'b1, 64'h66, 1'b1, 1'b1, 1'b0, 1'b0, 64'h55, 2'd0, 1'b1, 32'd5);
        vecs[17] = mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h55, 2'd0, 1'b1, 32'd5);
        vecs[18] = mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h55, 2'd0, 1'b1, 32'd0);

        rst = 1'b1;
        a_in.valid = 1'b1; a_in.data = 64'hDEAD; a_out.ready = 1'b0;
        a_flush = 1'b0; a_clr = 1'b0;
        b_in.valid = 1'b0; b_in.data = 8'h00; b_out.ready = 1'b0;
        b_flush = 1'b0; b_clr = 1'b0;
        c_in.valid = 1'b0; c_in.data = 16'h0000; c_out.ready = 1'b0;
        c_flush = 1'b0; c_clr = 1'b0;

        // Reset held three cycles with a valid upstream beat pending.
        repeat (3) @(posedge clk);
        #1;
        chk("rst a_valid", 64'(a_out.valid), 64'd0);
        chk("rst a_occ", 64'(a_occ), 64'd0);
        chk("rst a_data", a_out.data, PC_RESET_VAL);
        chk("rst a_stall", 64'(a_stall), 64'd0);
        chk("rst b_valid", 64'(b_out.valid), 64'd0);
        chk("rst c_stall", 64'(c_stall), 64'd0);
        rst = 1'b0;
        a_in.valid = 1'b0;
        #1;
        chk("rel a_in_ready", 64'(a_in.ready), 64'd1);
        chk("rel b_in_ready", 64'(b_in.ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            a_in.valid  = vecs[i].iv;
            a_in.data   = vecs[i].d;
            a_out.ready = vecs[i].ordy;
            a_flush     = vecs[i].fl;
            a_clr       = vecs[i].clr;
            tick();
            chk($sformatf("v%0d out_valid", i), 64'(a_out.valid), 64'(vecs[i].ov));
            chk($sformatf("v%0d out_data", i), a_out.data, vecs[i].od);
            chk($sformatf("v%0d occupancy", i), 64'(a_occ), 64'(vecs[i].occ));
            chk($sformatf("v%0d in_ready", i), 64'(a_in.ready), 64'(vecs[i].ir));
            chk($sformatf("v%0d stall_cnt", i), 64'(a_stall), 64'(vecs[i].st));
        end
        a_in.valid = 1'b0; a_flush = 1'b0; a_clr = 1'b0;

        // Single-entry stage: ready follows out_ready combinationally while holding.
        b_in.valid = 1'b1; b_in.data = 8'hA5; b_out.ready = 1'b0;
        tick();
        chk("b load valid", 64'(b_out.valid), 64'd1);
        chk("b load data", 64'(b_out.data), 64'hA5);
        chk("b load occ", 64'(b_occ), 64'd1);
        b_in.data = 8'h5A;
        #1;
        chk("b held in_ready", 64'(b_in.ready), 64'd0);
        b_out.ready = 1'b1;
        #1;
        chk("b pass in_ready", 64'(b_in.ready), 64'd1);
        tick();
        chk("b next data", 64'(b_out.data), 64'h5A);
        chk("b next valid", 64'(b_out.valid), 64'd1);
        chk("b next occ", 64'(b_occ), 64'd1);
        b_in.valid = 1'b0;
        tick();
        chk("b drain valid", 64'(b_out.valid), 64'd0);
        chk("b drain occ", 64'(b_occ), 64'd0);
        b_in.valid = 1'b1; b_in.data = 8'hC3; b_out.ready = 1'b0;
        tick();
        chk("b refill data", 64'(b_out.data), 64'hC3);
        b_in.valid = 1'b0; b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        chk("b flush valid", 64'(b_out.valid), 64'd0);
        chk("b flush occ", 64'(b_occ), 64'd0);
        chk("b flush data kept", 64'(b_out.data), 64'hC3);

        // 4-bit stall counter saturates at 15; clear wins over a concurrent stall.
        c_in.valid = 1'b1; c_in.data = 16'h0007; c_out.ready = 1'b0;
        tick();
        c_in.valid = 1'b0;
        chk("c load valid", 64'(c_out.valid), 64'd1);
        chk("c start stall", 64'(c_stall), 64'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("c stall %0d", i), 64'(c_stall), 64'((i > 15) ? 15 : i));
        end
        c_clr = 1'b1;
        tick();
        chk("c clr", 64'(c_stall), 64'd0);
        c_clr = 1'b0;
        tick();
        chk("c after clr", 64'(c_stall), 64'd1);
        chk("c still held", 64'(c_out.data), 64'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register that replaces hand-written per-stage latches such as the ID/EX register with one generic block.
- Carries an opaque DATA_W-bit payload under a valid/ready handshake.
- Provides flush (kill) and an optional 2-entry skid buffer that registers the upstream ready path.
- Exports a saturating stall-cycle counter for performance debug.
- Instantiated between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64: payload width in bits (packed stage bundle).
- RESET_VAL, {DATA_W{1'b0}}: payload value after reset.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload valid toward downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload toward downstream.
- flush  in  1  kill all held entries (branch/jump redirect).
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset: sync, active-high, one clock.
  - Registered outputs after reset: main_valid=0, skid_valid=0, out_valid=0, occupancy=0, stall_cnt=0.
  - main_data and skid_data reset to RESET_VAL, so out_data=RESET_VAL.
  - in_ready is high in the first cycle after reset is released.
  - Reset asserted mid-transfer discards all entries; no handshake completes in that cycle.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_valid = main_valid; out_data = main_data.
- Latency: one cycle from in_fire to out_valid when the stage is empty.
- SKID=1 state, encoded by {skid_valid, main_valid}: EMPTY (00), ONE (01), FULL (11).
  - in_ready = !skid_valid. It is a register output with no combinational path from out_ready.
  - EMPTY: in_fire loads main -> ONE.
  - ONE, in_fire & out_fire: main <= in_data, stays ONE.
  - ONE, in_fire & !out_fire: skid <= in_data -> FULL.
  - ONE, !in_fire & out_fire -> EMPTY.
  - FULL: in_ready=0. out_fire moves skid to main -> ONE.
  - Order is strictly preserved; a payload is never duplicated or dropped.
- SKID=0:
  - in_ready = !main_valid | out_ready (combinational).
  - in_fire loads main; out_fire without in_fire clears main_valid.
- Flush:
  - Highest priority after rst. Clears main_valid and skid_valid next edge; occupancy=0.
  - An in_fire in the same cycle is discarded. Upstream still sees in_ready as computed, so its handshake completes and the data is dropped.
  - Payload registers are not cleared on flush; only the valid bits are.
  - out_fire in the flush cycle still counts as delivered to downstream.
- Hold semantics: payload and valid registers change only on in_fire, out_fire, flush or rst. No register toggles while the stage is stalled.
- occupancy = main_valid + skid_valid, registered.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at all-ones.
  - stall_cnt_clr zeroes it; clear wins over a simultaneous increment.
  - Not affected by flush.
- Assertions for the bench:
  - skid_valid implies main_valid.
  - out_data stable while out_valid & !out_ready.
  - occupancy <= 1 when SKID=0.

Decomposition:
- Shared package pipe_pkg:
  - localparams for the occupancy encoding (OCC_EMPTY/ONE/FULL).
  - per-stage bundle widths ID_EX_W, EX_MEM_W, etc., used to size DATA_W.
  - default PC reset value 64'h8000_0000, placed in the bundle's RESET_VAL by the instantiator.
- One natural sub-module: sat_counter (CNT_W, inc, clr, sync active-high rst), used for stall_cnt.
- The skid logic stays inline and is selected with a generate on SKID.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 and in_data=64'hDEAD. Required: out_valid=0, occupancy=0, out_data=RESET_VAL; in_ready=1 the first cycle after release.
- Streaming, SKID=1: in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles. Required: out_data 1,2,3,4 one cycle later; occupancy=1 throughout; stall_cnt=0.
- Backpressure fill: send A=0x11 then B=0x22 with out_ready=0. Required: occupancy=2 and in_ready=0 next cycle; C=0x33 is not accepted; stall_cnt counts 1 per cycle. Then raise out_ready: outputs are 0x11, 0x22, then 0x33 in order.
- Flush collision: with FULL (0x11, 0x22), assert flush together with in_valid and in_data=0x44. Required: next cycle out_valid=0, occupancy=0, and 0x44 never appears at the output.
- SKID=0 pass-through: out_ready=0 with one entry held. Required: in_ready=0 combinationally. Raise out_ready: in_ready=1 the same cycle, and the new payload is on out_data next cycle.
- Counter: CNT_W=4, stall for 20 cycles. Required: stall_cnt saturates at 15. Assert stall_cnt_clr while still stalling: required stall_cnt=0 next cycle, then 1.
